// File: rtl/cv32e40p_config_pkg.sv
// cv32e40p_config_pkg: core-level configuration defaults shared by the FPU blocks.
package cv32e40p_config_pkg;
  localparam int FPU_ADDMUL_LAT = 1;
  localparam int FPU_OTHERS_LAT = 1;
endpackage

// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: FPU op classes and issue-tracker state encoding.
package cv32e40p_pkg;
  typedef enum logic [1:0] {
    OP_ADDMUL  = 2'd0,
    OP_OTHERS  = 2'd1,
    OP_DIVSQRT = 2'd2,
    OP_RSVD    = 2'd3
  } fpu_op_class_e;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PIPE     = 2'd1,
    DIV_WAIT = 2'd2
  } fpu_trk_state_e;
endpackage

// File: rtl/cv32e40p_fpu_lat_pipe.sv
// cv32e40p_fpu_lat_pipe: completion-slot shift register with WAW, structural and RAW match logic.
// Slot k (1-based) lives at bit k-1; a shift right by one slot advances every op toward writeback.
module cv32e40p_fpu_lat_pipe #(
  parameter int MAXLAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ins,
  input  logic [2:0]  lat,
  input  logic [5:0]  waddr,
  input  logic [17:0] rd_addr,
  input  logic [2:0]  rd_valid,
  output logic        head_valid,
  output logic [5:0]  head_waddr,
  output logic        more,
  output logic        struct_hit,
  output logic        waw_hit,
  output logic        rd_hit
);
  logic [MAXLAT-1:0]   v, v_n, v_lat;
  logic [6*MAXLAT-1:0] wa, wa_n;
  // The target slot is always empty after the shift, so insertion can simply OR in.
  always_comb begin
    v_n     = (v >> 1) | (MAXLAT'(ins) << (lat - 3'd1));
    wa_n    = (wa >> 6) | ((6*MAXLAT)'(ins ? waddr : 6'd0) << (6 * (lat - 3'd1)));
    v_lat   = v >> lat;
    waw_hit = 1'b0;
    rd_hit  = 1'b0;
    for (int k = 0; k < MAXLAT; k++) begin
      waw_hit = waw_hit | (v[k] && wa[6*k +: 6] == waddr);
      for (int j = 0; j < 3; j++)
        rd_hit = rd_hit | (v[k] && rd_valid[j] && wa[6*k +: 6] == rd_addr[6*j +: 6]);
    end
  end
  assign struct_hit = v_lat[0];
  assign more       = |(v >> 1);
  assign head_valid = v[0];
  assign head_waddr = wa[5:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v  <= '0;
      wa <= '0;
    end else begin
      v  <= v_n;
      wa <= wa_n;
    end
  end
endmodule

// File: rtl/cv32e40p_fpu_issue_tracker.sv
// cv32e40p_fpu_issue_tracker: issues FPU ops, tracks fixed-latency and div/sqrt completions,
// and flags WAW/structural/RAW hazards for the decode stage.
module cv32e40p_fpu_issue_tracker
  import cv32e40p_pkg::*;
#(
  parameter int FPU_ADDMUL_LAT = cv32e40p_config_pkg::FPU_ADDMUL_LAT,
  parameter int FPU_OTHERS_LAT = cv32e40p_config_pkg::FPU_OTHERS_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [1:0]  op_class_i,
  input  logic [5:0]  waddr_i,
  output logic        gnt_o,
  output logic        fpu_req_o,
  input  logic        fpu_gnt_i,
  input  logic        fpu_rvalid_i,
  output logic        rvalid_o,
  output logic [5:0]  rwaddr_o,
  input  logic [17:0] rd_addr_i,
  input  logic [2:0]  rd_valid_i,
  output logic        dep_stall_o,
  output logic        busy_o
);
  localparam int MAXLAT = FPU_ADDMUL_LAT > FPU_OTHERS_LAT ? FPU_ADDMUL_LAT : FPU_OTHERS_LAT;
  if (FPU_ADDMUL_LAT < 1 || FPU_ADDMUL_LAT > 4 || FPU_OTHERS_LAT < 1 || FPU_OTHERS_LAT > 4) begin : g_bad_lat
    $error("FPU latency parameters must lie in 1..4");
  end
  fpu_trk_state_e state;
  logic [5:0] div_waddr, head_waddr;
  logic [2:0] lat;
  logic fixed, is_div, hazard, div_done, div_rd;
  logic head_valid, more, struct_hit, waw_hit, rd_hit;
  assign fixed  = op_class_i == OP_ADDMUL || op_class_i == OP_OTHERS;
  assign is_div = op_class_i == OP_DIVSQRT;
  assign lat    = op_class_i == OP_ADDMUL ? 3'(FPU_ADDMUL_LAT) : 3'(FPU_OTHERS_LAT);
  // Div/sqrt needs a fully drained pipe; nothing issues while it is outstanding.
  assign hazard = state == DIV_WAIT || (is_div && state != IDLE) || (fixed && struct_hit) || waw_hit;
  // Gated by rst_n so no request leaks out while reset is held.
  assign fpu_req_o = rst_n & req_i & ~hazard & (op_class_i != OP_RSVD);
  assign gnt_o     = fpu_req_o & fpu_gnt_i;
  assign div_done  = state == DIV_WAIT && fpu_rvalid_i;
  assign rvalid_o  = head_valid | div_done;
  assign rwaddr_o  = div_done ? div_waddr : head_waddr;
  assign busy_o    = state != IDLE;
  always_comb begin
    div_rd = 1'b0;
    for (int j = 0; j < 3; j++)
      div_rd = div_rd | (state == DIV_WAIT && rd_valid_i[j] && rd_addr_i[6*j +: 6] == div_waddr);
  end
  assign dep_stall_o = rd_hit | div_rd;
  cv32e40p_fpu_lat_pipe #(.MAXLAT(MAXLAT)) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .ins        (gnt_o & fixed),
    .lat        (lat),
    .waddr      (waddr_i),
    .rd_addr    (rd_addr_i),
    .rd_valid   (rd_valid_i),
    .head_valid (head_valid),
    .head_waddr (head_waddr),
    .more       (more),
    .struct_hit (struct_hit),
    .waw_hit    (waw_hit),
    .rd_hit     (rd_hit)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_waddr <= '0;
    end else begin
      state <= state == IDLE ? (gnt_o ? (is_div ? DIV_WAIT : PIPE) : IDLE) :
               state == PIPE ? ((gnt_o || more) ? PIPE : IDLE) :
               (fpu_rvalid_i ? IDLE : DIV_WAIT);
      if (state == IDLE && gnt_o && is_div) div_waddr <= waddr_i;
    end
  end
endmodule

// File: tb/tb_cv32e40p_fpu_issue_tracker.sv
// tb_cv32e40p_fpu_issue_tracker: directed vectors with hand-computed expectations, ADDMUL_LAT=2, OTHERS_LAT=1.
module tb_cv32e40p_fpu_issue_tracker;
  logic        clk = 1'b0;
  logic        rst_n, req_i, gnt_o, fpu_req_o, fpu_gnt_i, fpu_rvalid_i, rvalid_o, dep_stall_o, busy_o;
  logic [1:0]  op_class_i;
  logic [5:0]  waddr_i, rwaddr_o;
  logic [17:0] rd_addr_i;
  logic [2:0]  rd_valid_i;
  int n_chk = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  cv32e40p_fpu_issue_tracker #(.FPU_ADDMUL_LAT(2), .FPU_OTHERS_LAT(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .op_class_i   (op_class_i),
    .waddr_i      (waddr_i),
    .gnt_o        (gnt_o),
    .fpu_req_o    (fpu_req_o),
    .fpu_gnt_i    (fpu_gnt_i),
    .fpu_rvalid_i (fpu_rvalid_i),
    .rvalid_o     (rvalid_o),
    .rwaddr_o     (rwaddr_o),
    .rd_addr_i    (rd_addr_i),
    .rd_valid_i   (rd_valid_i),
    .dep_stall_o  (dep_stall_o),
    .busy_o       (busy_o)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] cls, input logic [5:0] wa);
    req_i = 1'b1;
    op_class_i = cls;
    waddr_i = wa;
  endtask
  initial begin
    rst_n = 1'b0; fpu_gnt_i = 1'b1; fpu_rvalid_i = 1'b0;
    rd_addr_i = '0; rd_valid_i = '0;
    issue(2'd0, 6'd1);
    #3;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_fpu_req", fpu_req_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rwaddr", rwaddr_o, 0);
    chk("rst_dep", dep_stall_o, 0);
    chk("rst_busy", busy_o, 0);
    tick; tick;
    rst_n = 1'b1; req_i = 1'b0;
    tick;
    // single ADDMUL: completes two cycles after grant
    issue(2'd0, 6'd5); #1;
    chk("am_gnt", gnt_o, 1); chk("am_busy0", busy_o, 0);
    tick; req_i = 1'b0; #1;
    chk("am_rv_c1", rvalid_o, 0); chk("am_busy_c1", busy_o, 1);
    tick; #1;
    chk("am_rv_c2", rvalid_o, 1); chk("am_wa_c2", rwaddr_o, 5); chk("am_busy_c2", busy_o, 1);
    tick; #1;
    chk("am_rv_c3", rvalid_o, 0); chk("am_busy_c3", busy_o, 0);
    // slot collision: OTHERS behind ADDMUL
    issue(2'd0, 6'd3); #1;
    chk("col_gnt0", gnt_o, 1);
    tick; issue(2'd1, 6'd4); #1;
    chk("col_gnt1", gnt_o, 0); chk("col_req1", fpu_req_o, 0);
    tick; #1;
    chk("col_gnt2", gnt_o, 1); chk("col_rv2", rvalid_o, 1); chk("col_wa2", rwaddr_o, 3);
    tick; req_i = 1'b0; #1;
    chk("col_rv3", rvalid_o, 1); chk("col_wa3", rwaddr_o, 4);
    tick; #1;
    chk("col_rv4", rvalid_o, 0); chk("col_busy4", busy_o, 0);
    // RAW stall on operand slot 1
    issue(2'd1, 6'd7); rd_addr_i = {6'd0, 6'd7, 6'd0}; rd_valid_i = 3'b010; #1;
    chk("raw_dep0", dep_stall_o, 0); chk("raw_gnt0", gnt_o, 1);
    tick; req_i = 1'b0; #1;
    chk("raw_dep1", dep_stall_o, 1); chk("raw_rv1", rvalid_o, 1); chk("raw_wa1", rwaddr_o, 7);
    rd_valid_i = 3'b001; #1;
    chk("raw_unused_op", dep_stall_o, 0);
    rd_valid_i = 3'b010;
    tick; #1;
    chk("raw_dep2", dep_stall_o, 0); chk("raw_rv2", rvalid_o, 0);
    rd_valid_i = '0;
    // FPU refuses: no grant, nothing tracked
    issue(2'd0, 6'd6); fpu_gnt_i = 1'b0; #1;
    chk("nog_req", fpu_req_o, 1); chk("nog_gnt", gnt_o, 0);
    tick; fpu_gnt_i = 1'b1; req_i = 1'b0; #1;
    chk("nog_busy", busy_o, 0);
    issue(2'd3, 6'd6); fpu_rvalid_i = 1'b1; #1;
    chk("rsvd_req", fpu_req_o, 0); chk("stray_rvalid", rvalid_o, 0);
    fpu_rvalid_i = 1'b0; req_i = 1'b0;
    tick;
    // DIVSQRT: blocks everything until fpu_rvalid_i
    issue(2'd2, 6'd9); #1;
    chk("div_gnt", gnt_o, 1);
    tick; rd_addr_i = {12'd0, 6'd9}; rd_valid_i = 3'b001;
    for (int i = 1; i <= 10; i++) begin
      issue(2'(i % 3), 6'(i + 20)); #1;
      chk("div_wait_gnt", gnt_o, 0);
      chk("div_wait_rv", rvalid_o, 0);
      if (i == 1) begin
        chk("div_busy", busy_o, 1);
        chk("div_dep", dep_stall_o, 1);
      end
      tick;
    end
    fpu_rvalid_i = 1'b1; issue(2'd0, 6'd1); #1;
    chk("div_rv", rvalid_o, 1); chk("div_wa", rwaddr_o, 9); chk("div_done_gnt", gnt_o, 0);
    tick; fpu_rvalid_i = 1'b0; #1;
    chk("div_idle", busy_o, 0); chk("div_rv_after", rvalid_o, 0);
    chk("div_dep_after", dep_stall_o, 0); chk("div_idle_gnt", gnt_o, 1);
    req_i = 1'b0; rd_valid_i = '0;
    tick;
    // WAW: same destination back to back
    issue(2'd0, 6'd2); #1;
    chk("waw_gnt0", gnt_o, 1);
    tick; #1;
    chk("waw_gnt1", gnt_o, 0);
    tick; #1;
    chk("waw_gnt2", gnt_o, 0); chk("waw_rv2", rvalid_o, 1); chk("waw_wa2", rwaddr_o, 2);
    tick; #1;
    chk("waw_gnt3", gnt_o, 1);
    tick; req_i = 1'b0;
    tick; #1;
    chk("waw_rv5", rvalid_o, 1); chk("waw_wa5", rwaddr_o, 2);
    tick; #1;
    chk("waw_busy6", busy_o, 0);
    // reset with two ops in flight
    issue(2'd0, 6'd10); #1;
    chk("mr_gnt0", gnt_o, 1);
    tick; issue(2'd0, 6'd11); #1;
    chk("mr_gnt1", gnt_o, 1);
    tick; req_i = 1'b0; rd_addr_i = {12'd0, 6'd11}; rd_valid_i = 3'b001; #1;
    chk("mr_rv", rvalid_o, 1); chk("mr_wa", rwaddr_o, 10); chk("mr_dep", dep_stall_o, 1);
    rst_n = 1'b0; issue(2'd0, 6'd12); #1;
    chk("mr_rst_rv", rvalid_o, 0); chk("mr_rst_wa", rwaddr_o, 0);
    chk("mr_rst_busy", busy_o, 0); chk("mr_rst_dep", dep_stall_o, 0);
    chk("mr_rst_req", fpu_req_o, 0); chk("mr_rst_gnt", gnt_o, 0);
    tick; tick;
    rst_n = 1'b1; req_i = 1'b0; rd_valid_i = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mr_post_rv", rvalid_o, 0);
      tick;
    end
    chk("mr_post_busy", busy_o, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
